// File: rtl/soc_bus_pkg.sv
// Shared bus types for the SoC memory-side request path.
package soc_bus_pkg;

  typedef enum logic {
    MST_INSTR = 1'b0,
    MST_DATA  = 1'b1
  } bus_master_e;

  localparam int unsigned BUS_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/bus_id_fifo.sv
// Small synchronous FIFO used for bus-side bookkeeping queues (e.g. response owner IDs).
module bus_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin merge of instruction-fetch (m0) and load/store (m1) onto one memory port,
// with an in-order owner queue that routes each response back to its issuer.
module mem_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = BUS_MAX_OUTSTANDING
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [BE_WIDTH-1:0]   m0_be_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [BE_WIDTH-1:0]   m1_be_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  s_req_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic                  s_we_o,
  output logic [BE_WIDTH-1:0]   s_be_o,
  output logic [DATA_WIDTH-1:0] s_wdata_o,
  input  logic                  s_gnt_i,
  input  logic                  s_rvalid_i,
  input  logic [DATA_WIDTH-1:0] s_rdata_i,
  output logic                  resp_err_o
);

  // Handshake: a request transfers when req and gnt are both high in the same cycle;
  // a master holds req and its fields stable until gnt (or withdraws it), and every
  // transfer gets exactly one rvalid later, in issue order, with no back-pressure.

  bus_master_e last_grant;
  bus_master_e sel;
  bus_master_e head_id;
  logic        any_req;
  logic        q_full;
  logic        q_empty;
  logic [0:0]  q_head;
  logic        q_pop;
  logic        blocked;
  logic        accept;

  assign any_req = m0_req_i | m1_req_i;

  always_comb begin
    sel = MST_INSTR;
    if (m0_req_i && m1_req_i) begin
      sel = (last_grant == MST_INSTR) ? MST_DATA : MST_INSTR;
    end else if (m1_req_i) begin
      sel = MST_DATA;
    end
  end

  assign q_pop   = s_rvalid_i & ~q_empty & ~reset_i;
  assign blocked = q_full & ~q_pop;
  assign s_req_o = any_req & ~blocked & ~reset_i;
  assign accept  = s_req_o & s_gnt_i;

  assign m0_gnt_o = accept & (sel == MST_INSTR);
  assign m1_gnt_o = accept & (sel == MST_DATA);

  assign s_addr_o  = (sel == MST_DATA) ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = (sel == MST_DATA) ? m1_we_i    : m0_we_i;
  assign s_be_o    = (sel == MST_DATA) ? m1_be_i    : m0_be_i;
  assign s_wdata_o = (sel == MST_DATA) ? m1_wdata_i : m0_wdata_i;

  bus_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .push      (accept),
    .push_data (logic'(sel)),
    .pop       (q_pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign head_id     = bus_master_e'(q_head);
  assign m0_rvalid_o = q_pop & (head_id == MST_INSTR);
  assign m1_rvalid_o = q_pop & (head_id == MST_DATA);
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  // Master 0 wins the first conflict out of reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_grant <= MST_DATA;
    end else if (accept) begin
      last_grant <= sel;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      resp_err_o <= 1'b0;
    end else if (s_rvalid_i && q_empty) begin
      resp_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: request-side checker, response-side monitor, memory model.
module tb_mem_bus_arbiter;
  import soc_bus_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m_req   [2];
  logic [AW-1:0] m_addr  [2];
  logic          m_we    [2];
  logic [BW-1:0] m_be    [2];
  logic [DW-1:0] m_wdata [2];
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          s_req, s_we, s_gnt, s_rvalid, resp_err;
  logic [AW-1:0] s_addr;
  logic [BW-1:0] s_be;
  logic [DW-1:0] s_wdata, s_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BE_WIDTH (BW), .MAX_OUTSTANDING (DEPTH)
  ) dut (
    .clk_i (clk), .reset_i (reset),
    .m0_req_i (m_req[0]), .m0_addr_i (m_addr[0]), .m0_we_i (m_we[0]), .m0_be_i (m_be[0]),
    .m0_wdata_i (m_wdata[0]), .m0_gnt_o (m0_gnt), .m0_rvalid_o (m0_rvalid), .m0_rdata_o (m0_rdata),
    .m1_req_i (m_req[1]), .m1_addr_i (m_addr[1]), .m1_we_i (m_we[1]), .m1_be_i (m_be[1]),
    .m1_wdata_i (m_wdata[1]), .m1_gnt_o (m1_gnt), .m1_rvalid_o (m1_rvalid), .m1_rdata_o (m1_rdata),
    .s_req_o (s_req), .s_addr_o (s_addr), .s_we_o (s_we), .s_be_o (s_be), .s_wdata_o (s_wdata),
    .s_gnt_i (s_gnt), .s_rvalid_i (s_rvalid), .s_rdata_i (s_rdata), .resp_err_o (resp_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16]};
  endfunction

  // Scoreboard: owner order of accepted requests and expected read data per master.
  int            owner_q[$];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  bit            exp_err  = 1'b0;
  bit            pop_seen = 1'b0;
  int            last_win = 1;

  // Stimulus knobs.
  bit masters_on  = 1'b0;
  int req_pct     = 80;
  int drop_pct    = 5;
  int gnt_pct     = 100;
  int lat_max     = 1;
  bit inject_spur = 1'b0;

  // Response monitor: runs first each cycle, before any new grant is recorded.
  always @(negedge clk) begin : monitor
    int w;
    pop_seen = 1'b0;
    if (reset) begin
      check("rst_m0_rvalid", m0_rvalid, 0);
      check("rst_m1_rvalid", m1_rvalid, 0);
      check("rst_resp_err", resp_err, 0);
      owner_q.delete(); exp_q0.delete(); exp_q1.delete();
      exp_err = 1'b0;
    end else begin
      check("resp_err", resp_err, exp_err);
      check("m0_rdata_pass", m0_rdata, s_rdata);
      check("m1_rdata_pass", m1_rdata, s_rdata);
      if (s_rvalid && owner_q.size() > 0) begin
        w = owner_q.pop_front();
        pop_seen = 1'b1;
        check("m0_rvalid", m0_rvalid, (w == 0));
        check("m1_rvalid", m1_rvalid, (w == 1));
        if (w == 0) check("m0_resp_data", m0_rdata, exp_q0.pop_front());
        else        check("m1_resp_data", m1_rdata, exp_q1.pop_front());
      end else begin
        check("idle_m0_rvalid", m0_rvalid, 0);
        check("idle_m1_rvalid", m1_rvalid, 0);
        if (s_rvalid) exp_err = 1'b1;
      end
    end
  end

  // Request checker: predicts issue and grant from the requests and queue occupancy.
  always begin : req_checker
    int  occ;
    int  win;
    bit  exp_req;
    bit  exp_acc;
    @(negedge clk);
    #1;
    if (reset) begin
      check("rst_s_req", s_req, 0);
      check("rst_m0_gnt", m0_gnt, 0);
      check("rst_m1_gnt", m1_gnt, 0);
      last_win = 1;
    end else begin
      occ     = owner_q.size() + int'(pop_seen);
      exp_req = (m_req[0] || m_req[1]) && !(occ == DEPTH && !pop_seen);
      if (m_req[0] && m_req[1]) win = 1 - last_win;
      else                      win = m_req[1] ? 1 : 0;
      exp_acc = exp_req && s_gnt;
      check("s_req", s_req, exp_req);
      check("m0_gnt", m0_gnt, exp_acc && win == 0);
      check("m1_gnt", m1_gnt, exp_acc && win == 1);
      if (exp_req) begin
        check("s_addr", s_addr, m_addr[win]);
        check("s_we", s_we, m_we[win]);
        check("s_be", s_be, m_be[win]);
        check("s_wdata", s_wdata, m_wdata[win]);
      end
      if (exp_acc) begin
        last_win = win;
        owner_q.push_back(win);
        if (win == 0) exp_q0.push_back(rdata_of(m_addr[0]));
        else          exp_q1.push_back(rdata_of(m_addr[1]));
      end
    end
  end

  task automatic drive_master(input int i, input bit granted);
    if (!m_req[i] || granted) begin
      if (masters_on && $urandom_range(99) < req_pct) begin
        m_req[i]   = 1'b1;
        m_addr[i]  = $urandom;
        m_we[i]    = 1'($urandom_range(1));
        m_be[i]    = 4'($urandom_range(15));
        m_wdata[i] = $urandom;
      end else begin
        m_req[i] = 1'b0;
      end
    end else if ($urandom_range(99) < drop_pct) begin
      m_req[i] = 1'b0;
    end
  endtask

  initial begin : master_driver
    bit g0, g1;
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 1'b0; m_addr[i] = '0; m_we[i] = 1'b0; m_be[i] = '0; m_wdata[i] = '0;
    end
    forever begin
      @(negedge clk);
      g0 = m0_gnt;
      g1 = m1_gnt;
      @(posedge clk);
      #1;
      drive_master(0, g0);
      drive_master(1, g1);
    end
  end

  // In-order memory with random per-request latency (>= 1 cycle) and random gnt.
  initial begin : memory_model
    int            cyc;
    int            due;
    int            last_due;
    int            due_q[$];
    logic [DW-1:0] dat_q[$];
    bit            acc;
    logic [AW-1:0] a;
    s_gnt = 1'b1; s_rvalid = 1'b0; s_rdata = '0;
    cyc = 0; last_due = 0;
    forever begin
      @(negedge clk);
      acc = s_req && s_gnt;
      a   = s_addr;
      @(posedge clk);
      cyc++;
      if (acc) begin
        due = cyc + int'($urandom_range(lat_max - 1, 0));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        due_q.push_back(due);
        dat_q.push_back(rdata_of(a));
      end
      #1;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        s_rvalid = 1'b1;
        s_rdata  = dat_q.pop_front();
        void'(due_q.pop_front());
      end else if (inject_spur && due_q.size() == 0) begin
        s_rvalid    = 1'b1;
        s_rdata     = $urandom;
        inject_spur = 1'b0;
      end else begin
        s_rvalid = 1'b0;
        s_rdata  = $urandom;
      end
      s_gnt = ($urandom_range(99) < gnt_pct);
    end
  end

  initial begin : main
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    // Heavy conflict, zero-wait memory: alternation and full throughput.
    masters_on = 1'b1; req_pct = 90; gnt_pct = 100; lat_max = 1;
    repeat (300) @(posedge clk);
    // Back-pressure and slow responses: queue fills and blocks.
    req_pct = 60; gnt_pct = 60; lat_max = 4;
    repeat (400) @(posedge clk);
    // Drain, then a response with nothing outstanding.
    masters_on = 1'b0;
    repeat (20) @(posedge clk);
    #1 inject_spur = 1'b1;
    repeat (10) @(posedge clk);
    // Reset while requests are in flight; late responses afterwards.
    masters_on = 1'b1; req_pct = 90; gnt_pct = 100; lat_max = 3;
    repeat (50) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (300) @(posedge clk);
    masters_on = 1'b0;
    repeat (20) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
